split_eval_seq: RTL and testbench

SPLIT_EVAL_SEQ -- requirements
Module: split_eval_seq

---
 rtl/split_eval_seq_if.sv | 46 ++++
 rtl/split_eval_seq.sv | 156 +++++++++++++++
 tb/tb_split_eval_seq.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/split_eval_seq_if.sv
// ---------------------------------------------------------------------------
// split_eval_seq_if
// Bundles the configuration port, the variable-sample stream and the verdict
// handshake of split_eval_seq.
//   cfg_we/cfg_idx/cfg_en/cfg_lo/cfg_hi : constraint write (taken only in IDLE)
//   in_valid/in_ready/in_idx/in_data/in_last : one variable sample per beat
//   res_valid/res_ready/x/fail_idx/idx_err   : frame verdict, held until taken
// modport slave  : the checker side (split_eval_seq)
// modport master : the side that drives config and samples
// ---------------------------------------------------------------------------
interface split_eval_seq_if #(
    parameter int VAR_W = 8,
    parameter int IDX_W = 6
);
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic             cfg_en;
    logic [VAR_W-1:0] cfg_lo;
    logic [VAR_W-1:0] cfg_hi;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic [VAR_W-1:0] in_data;
    logic             in_last;

    logic             res_valid;
    logic             res_ready;
    logic             x;
    logic [IDX_W-1:0] fail_idx;
    logic             idx_err;

    modport slave (
        input  cfg_we, cfg_idx, cfg_en, cfg_lo, cfg_hi,
        input  in_valid, in_idx, in_data, in_last,
        input  res_ready,
        output in_ready, res_valid, x, fail_idx, idx_err
    );

    modport master (
        output cfg_we, cfg_idx, cfg_en, cfg_lo, cfg_hi,
        output in_valid, in_idx, in_data, in_last,
        output res_ready,
        input  in_ready, res_valid, x, fail_idx, idx_err
    );
endinterface

// File: rtl/split_eval_seq.sv
// ---------------------------------------------------------------------------
// split_eval_seq
// Collects one frame of indexed variable samples, then scans the stored
// values against per-variable inclusive [lo,hi] range constraints, one index
// per cycle, stopping at the first enabled constraint that is violated or
// whose variable was never sent. The verdict is held until handshaken.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (config, frame and FSM)
//   bus  : split_eval_seq_if.slave (config, sample stream, verdict)
// ---------------------------------------------------------------------------
module split_eval_seq #(
    parameter int NUM_VARS = 40,
    parameter int VAR_W    = 8,
    parameter int IDX_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    split_eval_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, EVAL, RESULT} state_t;

    // One extra bit so the bound stays exact even when 2**IDX_W == NUM_VARS.
    localparam logic [IDX_W:0]   NV_EXT   = (IDX_W+1)'(NUM_VARS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

    state_t           state_q;
    logic             in_ready_q;
    logic             res_valid_q;
    logic             x_q;
    logic [IDX_W-1:0] fail_idx_q;
    logic             idx_err_q;
    logic [IDX_W-1:0] scan_q;

    logic             en_q   [NUM_VARS];
    logic [VAR_W-1:0] lo_q   [NUM_VARS];
    logic [VAR_W-1:0] hi_q   [NUM_VARS];
    logic             seen_q [NUM_VARS];
    logic [VAR_W-1:0] val_q  [NUM_VARS];

    logic accept;
    logic in_ok;
    logic cfg_take;
    logic res_take;
    logic fail_d;

    assign accept   = bus.in_valid & in_ready_q;
    assign in_ok    = ({1'b0, bus.in_idx} < NV_EXT);
    assign cfg_take = bus.cfg_we & (state_q == IDLE);
    assign res_take = (state_q == RESULT) & bus.res_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.x         = x_q;
    assign bus.fail_idx  = fail_idx_q;
    assign bus.idx_err   = idx_err_q;

    // Does the index under scan violate its constraint?
    always_comb begin
        fail_d = 1'b0;
        for (int i = 0; i < NUM_VARS; i++) begin
            if (scan_q == IDX_W'(i)) begin
                fail_d = en_q[i] & (~seen_q[i] | (val_q[i] < lo_q[i]) | (val_q[i] > hi_q[i]));
            end
        end
    end

    // Sample values: no reset needed, every use is qualified by seen_q.
    // Out-of-range indices never match an entry, so they are dropped here.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_VARS; i++) begin
            if (accept && bus.in_idx == IDX_W'(i)) begin
                val_q[i] <= bus.in_data;
            end
        end
    end

    // Constraint table and per-frame seen flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VARS; i++) begin
                en_q[i]   <= 1'b0;
                lo_q[i]   <= '0;
                hi_q[i]   <= '1;
                seen_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_VARS; i++) begin
                if (cfg_take && bus.cfg_idx == IDX_W'(i)) begin
                    en_q[i] <= bus.cfg_en;
                    lo_q[i] <= bus.cfg_lo;
                    hi_q[i] <= bus.cfg_hi;
                end
                if (res_take) begin
                    seen_q[i] <= 1'b0;
                end else if (accept && bus.in_idx == IDX_W'(i)) begin
                    seen_q[i] <= 1'b1;
                end
            end
        end
    end

    // Frame FSM with registered handshake and verdict outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            x_q         <= 1'b1;
            fail_idx_q  <= '0;
            idx_err_q   <= 1'b0;
            scan_q      <= '0;
        end else begin
            case (state_q)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (!in_ok) begin
                            idx_err_q <= 1'b1;
                        end
                        if (bus.in_last) begin
                            state_q    <= EVAL;
                            in_ready_q <= 1'b0;
                            scan_q     <= '0;
                        end else begin
                            state_q <= COLLECT;
                        end
                    end
                end
                EVAL: begin
                    if (fail_d) begin
                        state_q     <= RESULT;
                        res_valid_q <= 1'b1;
                        x_q         <= 1'b0;
                        fail_idx_q  <= scan_q;
                    end else if (scan_q == LAST_IDX) begin
                        state_q     <= RESULT;
                        res_valid_q <= 1'b1;
                        x_q         <= 1'b1;
                        fail_idx_q  <= '0;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        idx_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_split_eval_seq.sv
module tb_split_eval_seq;
    localparam int NV = 40;
    localparam int VW = 8;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    split_eval_seq_if #(.VAR_W(VW), .IDX_W(IW)) bus ();

    split_eval_seq #(.NUM_VARS(NV), .VAR_W(VW), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: constraint table plus the current frame's contents.
    bit m_en [NV];
    int m_lo [NV];
    int m_hi [NV];
    bit m_seen [NV];
    int m_val [NV];
    bit m_err;

    typedef struct {
        int idx;
        int data;
    } smp_t;
    smp_t frame[$];

    // Observations of the last frame
    bit o_x, o_err, o_to;
    int o_fi, o_lat;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_en[i] = 0; m_lo[i] = 0; m_hi[i] = 255; m_seen[i] = 0; m_val[i] = 0;
        end
        m_err = 0;
    endtask

    task automatic model_clear_frame();
        for (int i = 0; i < NV; i++) m_seen[i] = 0;
        m_err = 0;
    endtask

    // Verdict: first enabled constraint that is unseen or out of range.
    // Scan covers one index per cycle after the in_last beat, verdict one
    // cycle after the stopping index: failing at i is visible in cycle i+2.
    function automatic void model_verdict(output bit ex_x, output int ex_fi, output int ex_lat);
        ex_x = 1; ex_fi = 0; ex_lat = NV + 1;
        for (int i = 0; i < NV; i++) begin
            if (m_en[i] && (!m_seen[i] || m_val[i] < m_lo[i] || m_val[i] > m_hi[i])) begin
                ex_x = 0; ex_fi = i; ex_lat = i + 2;
                break;
            end
        end
    endfunction

    task automatic cfg_write(input int idx, input bit en, input int lo, input int hi);
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = idx[IW-1:0];
        bus.cfg_en  = en;
        bus.cfg_lo  = lo[VW-1:0];
        bus.cfg_hi  = hi[VW-1:0];
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        if (idx < NV) begin
            m_en[idx] = en; m_lo[idx] = lo; m_hi[idx] = hi;
        end
    endtask

    task automatic shuffle_frame();
        for (int i = frame.size() - 1; i > 0; i--) begin
            int j;
            smp_t t;
            j = $urandom_range(0, i);
            t = frame[i]; frame[i] = frame[j]; frame[j] = t;
        end
    endtask

    task automatic push_smp(input int idx, input int data);
        smp_t s;
        s.idx = idx; s.data = data;
        frame.push_back(s);
    endtask

    // Sends the queued frame (in_last on the final beat), optionally with a
    // config write on the first beat (taken) and another on the second beat
    // (must be ignored), then waits a bounded time for res_valid.
    task automatic run_frame(input bit cfg0, input int c_idx, input bit c_en, input int c_lo,
                             input int c_hi, input bit cfg_late);
        for (int k = 0; k < frame.size(); k++) begin
            bus.in_valid = 1'b1;
            bus.in_idx   = frame[k].idx[IW-1:0];
            bus.in_data  = frame[k].data[VW-1:0];
            bus.in_last  = (k == frame.size() - 1);
            if (k == 0 && cfg0) begin
                bus.cfg_we = 1'b1; bus.cfg_idx = c_idx[IW-1:0]; bus.cfg_en = c_en;
                bus.cfg_lo = c_lo[VW-1:0]; bus.cfg_hi = c_hi[VW-1:0];
                if (c_idx < NV) begin
                    m_en[c_idx] = c_en; m_lo[c_idx] = c_lo; m_hi[c_idx] = c_hi;
                end
            end
            if (k == 1 && cfg_late) begin
                bus.cfg_we = 1'b1; bus.cfg_idx = IW'($urandom_range(0, NV - 1));
                bus.cfg_en = 1'b1; bus.cfg_lo = 8'hFF; bus.cfg_hi = 8'h00;
            end
            @(posedge clk); #1;
            bus.cfg_we = 1'b0;
            if (frame[k].idx < NV) begin
                m_seen[frame[k].idx] = 1; m_val[frame[k].idx] = frame[k].data;
            end else begin
                m_err = 1;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        o_lat = 1; o_to = 0;
        while (!bus.res_valid) begin
            if (o_lat > 100) begin o_to = 1; break; end
            @(posedge clk); #1;
            o_lat++;
        end
        o_x = bus.x; o_fi = int'(bus.fail_idx); o_err = bus.idx_err;
    endtask

    task automatic handshake(input int delay);
        repeat (delay) begin @(posedge clk); #1; end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        model_clear_frame();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.res_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.res_ready = 1'b0;
        model_reset();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %0b expected 0", bus.res_valid); end
        tests++; if (bus.x !== 1'b1) begin fails++; $display("FAIL reset_x: got %0b expected 1", bus.x); end
        tests++; if (bus.fail_idx !== '0) begin fails++; $display("FAIL reset_fail_idx: got %0d expected 0", bus.fail_idx); end
        tests++; if (bus.idx_err !== 1'b0) begin fails++; $display("FAIL reset_idx_err: got %0b expected 0", bus.idx_err); end
    endtask

    task automatic test_no_config();
        bit ex_x; int ex_fi, ex_lat;
        frame.delete();
        for (int i = 0; i < NV; i++) push_smp(i, $urandom_range(0, 255));
        run_frame(0, 0, 0, 0, 0, 0);
        model_verdict(ex_x, ex_fi, ex_lat);
        tests++; if (o_to) begin fails++; $display("FAIL noconf_timeout: got no res_valid expected within %0d", ex_lat); end
        tests++; if (o_x !== ex_x) begin fails++; $display("FAIL noconf_x: got %0b expected %0b", o_x, ex_x); end
        tests++; if (o_fi !== ex_fi) begin fails++; $display("FAIL noconf_fail_idx: got %0d expected %0d", o_fi, ex_fi); end
        tests++; if (o_lat !== ex_lat) begin fails++; $display("FAIL noconf_latency: got %0d expected %0d", o_lat, ex_lat); end
        handshake(0);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL noconf_ready_after: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_range_fail();
        bit ex_x; int ex_fi, ex_lat;
        cfg_write(5, 1, 10, 20);
        frame.delete();
        for (int i = 0; i < NV; i++) push_smp(i, (i == 5) ? 21 : $urandom_range(0, 255));
        run_frame(0, 0, 0, 0, 0, 0);
        model_verdict(ex_x, ex_fi, ex_lat);
        tests++; if (o_x !== ex_x || o_to) begin fails++; $display("FAIL range_x: got %0b expected %0b", o_x, ex_x); end
        tests++; if (o_fi !== ex_fi) begin fails++; $display("FAIL range_fail_idx: got %0d expected %0d", o_fi, ex_fi); end
        tests++; if (o_lat !== ex_lat) begin fails++; $display("FAIL range_latency: got %0d expected %0d", o_lat, ex_lat); end
        handshake(1);
    endtask

    task automatic test_missing_idx();
        bit ex_x; int ex_fi, ex_lat;
        cfg_write(3, 1, 0, 255);
        frame.delete();
        for (int i = 0; i < NV; i++) if (i != 3) push_smp(i, (i == 5) ? 15 : $urandom_range(0, 255));
        shuffle_frame();
        run_frame(0, 0, 0, 0, 0, 0);
        model_verdict(ex_x, ex_fi, ex_lat);
        tests++; if (o_x !== ex_x || o_to) begin fails++; $display("FAIL missing_x: got %0b expected %0b", o_x, ex_x); end
        tests++; if (o_fi !== ex_fi) begin fails++; $display("FAIL missing_fail_idx: got %0d expected %0d", o_fi, ex_fi); end
        handshake(0);
    endtask

    task automatic test_dup_backpressure();
        bit ex_x; int ex_fi, ex_lat;
        bit bad;
        frame.delete();
        push_smp(5, 25);
        for (int i = 0; i < NV; i++) if (i != 5) push_smp(i, (i == 3) ? $urandom_range(0, 255) : $urandom_range(0, 255));
        push_smp(45, 7);
        push_smp(5, 15);
        run_frame(0, 0, 0, 0, 0, 0);
        model_verdict(ex_x, ex_fi, ex_lat);
        tests++; if (o_x !== ex_x || o_to) begin fails++; $display("FAIL dup_x: got %0b expected %0b", o_x, ex_x); end
        tests++; if (o_err !== m_err) begin fails++; $display("FAIL dup_idx_err: got %0b expected %0b", o_err, m_err); end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.res_valid !== 1'b1 || bus.x !== ex_x || int'(bus.fail_idx) !== ex_fi ||
                bus.in_ready !== 1'b0 || bus.idx_err !== 1'b1) bad = 1;
            @(posedge clk); #1;
        end
        tests++; if (bad) begin fails++; $display("FAIL hold_stable: got change while res_ready=0 expected stable verdict"); end
        handshake(0);
        tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL hold_release_valid: got %0b expected 0", bus.res_valid); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL hold_release_ready: got %0b expected 1", bus.in_ready); end
        tests++; if (bus.idx_err !== 1'b0) begin fails++; $display("FAIL hold_release_idx_err: got %0b expected 0", bus.idx_err); end
    endtask

    task automatic test_tautology();
        bit ex_x; int ex_fi, ex_lat;
        for (int i = 0; i < NV; i++) cfg_write(i, 0, 200, 100);
        frame.delete();
        for (int i = 0; i < NV; i += 3) push_smp(i, $urandom_range(0, 255));
        run_frame(0, 0, 0, 0, 0, 0);
        model_verdict(ex_x, ex_fi, ex_lat);
        tests++; if (o_x !== ex_x || o_to) begin fails++; $display("FAIL taut_x: got %0b expected %0b", o_x, ex_x); end
        tests++; if (o_lat !== ex_lat) begin fails++; $display("FAIL taut_latency: got %0d expected %0d", o_lat, ex_lat); end
        handshake(0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 24; it++) begin
            bit ex_x; int ex_fi, ex_lat;
            int n_cfg, lo, hi, nd;
            n_cfg = $urandom_range(0, 4);
            for (int c = 0; c < n_cfg; c++) begin
                if ($urandom_range(0, 5) == 0) begin lo = $urandom_range(128, 255); hi = $urandom_range(0, 127); end
                else begin lo = $urandom_range(0, 60); hi = $urandom_range(180, 255); end
                cfg_write($urandom_range(0, 63), $urandom_range(0, 1), lo, hi);
            end
            frame.delete();
            for (int i = 0; i < NV; i++) if ($urandom_range(0, 19) != 0) push_smp(i, $urandom_range(0, 255));
            nd = $urandom_range(0, 2);
            for (int d = 0; d < nd; d++) push_smp($urandom_range(0, NV - 1), $urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) push_smp($urandom_range(NV, 63), $urandom_range(0, 255));
            if (frame.size() == 0) push_smp(0, 0);
            shuffle_frame();
            lo = $urandom_range(0, 60); hi = $urandom_range(150, 255);
            run_frame($urandom_range(0, 1), $urandom_range(0, 63), $urandom_range(0, 1), lo, hi,
                      $urandom_range(0, 1));
            model_verdict(ex_x, ex_fi, ex_lat);
            tests++; if (o_to) begin fails++; $display("FAIL rand%0d_timeout: got no res_valid expected latency %0d", it, ex_lat); end
            tests++; if (o_x !== ex_x) begin fails++; $display("FAIL rand%0d_x: got %0b expected %0b", it, o_x, ex_x); end
            tests++; if (o_fi !== ex_fi) begin fails++; $display("FAIL rand%0d_fail_idx: got %0d expected %0d", it, o_fi, ex_fi); end
            tests++; if (o_lat !== ex_lat) begin fails++; $display("FAIL rand%0d_latency: got %0d expected %0d", it, o_lat, ex_lat); end
            tests++; if (o_err !== m_err) begin fails++; $display("FAIL rand%0d_idx_err: got %0b expected %0b", it, o_err, m_err); end
            handshake($urandom_range(0, 3));
        end
    endtask

    task automatic test_rst_eval();
        bit ex_x; int ex_fi, ex_lat;
        bit seen_valid;
        cfg_write(7, 1, 100, 100);
        for (int i = 0; i < NV; i++) if (i != 7) cfg_write(i, 0, 0, 255);
        frame.delete();
        for (int i = 0; i < NV; i++) push_smp(i, (i == 7) ? 100 : 0);
        for (int k = 0; k < frame.size(); k++) begin
            bus.in_valid = 1'b1; bus.in_idx = frame[k].idx[IW-1:0];
            bus.in_data = frame[k].data[VW-1:0]; bus.in_last = (k == frame.size() - 1);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL rst_eval_valid: got %0b expected 0", bus.res_valid); end
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_eval_ready: got %0b expected 1", bus.in_ready); end
        seen_valid = 0;
        for (int c = 0; c < NV + 5; c++) begin
            if (bus.res_valid !== 1'b0) seen_valid = 1;
            @(posedge clk); #1;
        end
        tests++; if (seen_valid) begin fails++; $display("FAIL rst_eval_abort: got res_valid after abort expected none"); end
        frame.delete();
        for (int i = 0; i < NV; i++) if (i != 7) push_smp(i, 0);
        run_frame(0, 0, 0, 0, 0, 0);
        model_verdict(ex_x, ex_fi, ex_lat);
        tests++; if (o_x !== ex_x || o_to) begin fails++; $display("FAIL rst_eval_next_x: got %0b expected %0b", o_x, ex_x); end
        tests++; if (o_fi !== ex_fi) begin fails++; $display("FAIL rst_eval_next_fail_idx: got %0d expected %0d", o_fi, ex_fi); end
        handshake(0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no completion expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_en = 0; bus.cfg_lo = '0; bus.cfg_hi = '0;
        bus.in_valid = 0; bus.in_idx = '0; bus.in_data = '0; bus.in_last = 0; bus.res_ready = 0;
        test_reset();
        test_no_config();
        test_range_fail();
        test_missing_idx();
        test_dup_backpressure();
        test_tautology();
        test_random();
        test_rst_eval();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
